// File: rtl/usr_pkg.sv
// Shared types and encodings for the universal shift-register sequencer.
package usr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TX_SHIFT = 2'd1,
        RX_SHIFT = 2'd2,
        RX_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic {
        GNT_TX = 1'b0,
        GNT_RX = 1'b1
    } gnt_e;

endpackage

// File: rtl/usr_rr_arb.sv
// Two-requester round-robin arbiter; prio points at the requester that wins a tie.
module usr_rr_arb
    import usr_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_tx,
    input  logic req_rx,
    output logic gnt_valid,
    output gnt_e gnt
);

    gnt_e prio_q, prio_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= GNT_TX;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt       = GNT_TX;
        prio_d    = prio_q;
        if (en && (req_tx || req_rx)) begin
            gnt_valid = 1'b1;
            if (req_tx && (!req_rx || prio_q == GNT_TX)) begin
                gnt = GNT_TX;
            end else begin
                gnt = GNT_RX;
            end
            // Any grant hands priority to the other side, contested or not.
            prio_d = (gnt == GNT_TX) ? GNT_RX : GNT_TX;
        end
    end

endmodule

// File: rtl/usr_seq_ctrl.sv
// Sequencer time-sharing one universal shift register between a TX serializer
// and an RX deserializer, with round-robin arbitration in IDLE.
module usr_seq_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_msb_first,
    output logic             tx_ready,
    output logic             ser_out,
    output logic             ser_out_valid,
    input  logic             rx_start,
    input  logic             rx_bit_valid,
    input  logic             rx_bit,
    input  logic             rx_abort,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_data_valid,
    output logic             busy,
    output logic [1:0]       sr_sel,
    output logic [WIDTH-1:0] sr_d,
    output logic             sr_sin_left,
    output logic             sr_sin_right,
    input  logic [WIDTH-1:0] sr_q
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_data_valid_q, rx_data_valid_d;

    logic arb_en;
    logic gnt_valid;
    gnt_e gnt;

    // Gating with rst keeps tx_ready and the load strobe low while reset is held.
    assign arb_en = rst && (state_q == IDLE);

    usr_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst),
        .en        (arb_en),
        .req_tx    (tx_valid),
        .req_rx    (rx_start),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            dir_q           <= 1'b0;
            rx_data_q       <= '0;
            rx_data_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            dir_q           <= dir_d;
            rx_data_q       <= rx_data_d;
            rx_data_valid_q <= rx_data_valid_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        dir_d           = dir_q;
        rx_data_d       = rx_data_q;
        rx_data_valid_d = 1'b0;
        sr_sel          = SEL_HOLD;
        sr_d            = '0;
        sr_sin_left     = 1'b0;
        sr_sin_right    = 1'b0;
        tx_ready        = 1'b0;
        ser_out         = 1'b0;
        ser_out_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    sr_sel = SEL_LOAD;
                    cnt_d  = '0;
                    if (gnt == GNT_TX) begin
                        tx_ready = 1'b1;
                        sr_d     = tx_data;
                        dir_d    = tx_msb_first;
                        state_d  = TX_SHIFT;
                    end else begin
                        state_d = RX_SHIFT;
                    end
                end
            end
            TX_SHIFT: begin
                ser_out_valid = 1'b1;
                ser_out       = dir_q ? sr_q[WIDTH-1] : sr_q[0];
                sr_sel        = dir_q ? SEL_SHL : SEL_SHR;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_SHIFT: begin
                if (rx_abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (rx_bit_valid) begin
                    sr_sel       = SEL_SHR;
                    sr_sin_right = rx_bit;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = RX_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RX_DONE: begin
                rx_data_d       = sr_q;
                rx_data_valid_d = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign rx_data       = rx_data_q;
    assign rx_data_valid = rx_data_valid_q;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Randomized self-checking bench for usr_seq_ctrl with an attached shift-register model.
module tb_usr_seq_ctrl;
    import usr_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tx_valid = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_msb_first = 1'b0;
    logic         tx_ready, ser_out, ser_out_valid;
    logic         rx_start = 1'b0, rx_bit_valid = 1'b0, rx_bit = 1'b0, rx_abort = 1'b0;
    logic [W-1:0] rx_data;
    logic         rx_data_valid, busy;
    logic [1:0]   sr_sel;
    logic [W-1:0] sr_d;
    logic         sr_sin_left, sr_sin_right;
    logic [W-1:0] reg_q = '0;

    int n_tests = 0;
    int n_fail  = 0;
    bit prio_rx = 1'b0;

    always #5 clk = ~clk;

    // The external universal shift register the sequencer drives; it has no reset.
    always @(posedge clk) begin
        case (sr_sel)
            2'b01:   reg_q <= {sr_sin_right, reg_q[W-1:1]};
            2'b10:   reg_q <= {reg_q[W-2:0], sr_sin_left};
            2'b11:   reg_q <= sr_d;
            default: reg_q <= reg_q;
        endcase
    end

    usr_seq_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_msb_first  (tx_msb_first),
        .tx_ready      (tx_ready),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .rx_start      (rx_start),
        .rx_bit_valid  (rx_bit_valid),
        .rx_bit        (rx_bit),
        .rx_abort      (rx_abort),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .busy          (busy),
        .sr_sel        (sr_sel),
        .sr_d          (sr_d),
        .sr_sin_left   (sr_sin_left),
        .sr_sin_right  (sr_sin_right),
        .sr_q          (reg_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge in IDLE; drives the requests and checks the grant cycle.
    task automatic request(input bit want_tx, input bit want_rx, input logic [W-1:0] d,
                           input bit msb, output bit tx_won);
        tx_valid     = want_tx;
        tx_data      = d;
        tx_msb_first = msb;
        rx_start     = want_rx;
        rx_bit_valid = 1'b0;
        rx_abort     = 1'b0;
        #1;
        if (want_tx && want_rx) tx_won = !prio_rx;
        else                    tx_won = want_tx;
        prio_rx = tx_won;
        check("gnt_busy", busy, 0);
        check("gnt_txrdy", tx_ready, tx_won);
        check("gnt_sel", sr_sel, SEL_LOAD);
        check("gnt_d", sr_d, tx_won ? d : '0);
        @(negedge clk);
    endtask

    task automatic tx_body(input logic [W-1:0] d, input bit msb);
        for (int unsigned i = 0; i < W; i++) begin
            tx_valid = 1'b0;
            rx_start = 1'($urandom_range(0, 1));
            #1;
            check("tx_sov", ser_out_valid, 1);
            check("tx_bit", ser_out, msb ? d[W-1-i] : d[i]);
            check("tx_sel", sr_sel, msb ? SEL_SHL : SEL_SHR);
            check("tx_rxdv", rx_data_valid, 0);
            @(negedge clk);
        end
        rx_start = 1'b0;
        #1;
        check("tx_end_busy", busy, 0);
        check("tx_end_sov", ser_out_valid, 0);
    endtask

    task automatic rx_body(input logic [W-1:0] d, input int unsigned abort_at,
                           input logic [7:0] gaps_fixed, input bit rand_gaps);
        int unsigned g;
        for (int unsigned i = 0; i < W; i++) begin
            g = rand_gaps ? $urandom_range(0, 2) : 32'(gaps_fixed[2*i +: 2]);
            for (int unsigned k = 0; k < g; k++) begin
                rx_start     = 1'($urandom_range(0, 1));
                tx_valid     = 1'($urandom_range(0, 1));
                rx_bit_valid = 1'b0;
                rx_bit       = 1'($urandom_range(0, 1));
                rx_abort     = 1'b0;
                #1;
                check("rx_gap_sel", sr_sel, SEL_HOLD);
                check("rx_gap_txrdy", tx_ready, 0);
                check("rx_gap_busy", busy, 1);
                @(negedge clk);
            end
            if (i == abort_at) begin
                rx_abort     = 1'b1;
                rx_bit_valid = 1'($urandom_range(0, 1));
                rx_start     = 1'b0;
                tx_valid     = 1'b0;
                #1;
                check("rx_abort_sel", sr_sel, SEL_HOLD);
                @(negedge clk);
                rx_abort     = 1'b0;
                rx_bit_valid = 1'b0;
                #1;
                check("rx_abort_busy", busy, 0);
                check("rx_abort_dv", rx_data_valid, 0);
                return;
            end
            rx_bit_valid = 1'b1;
            rx_bit       = d[i];
            rx_start     = 1'($urandom_range(0, 1));
            tx_valid     = 1'($urandom_range(0, 1));
            #1;
            check("rx_sel", sr_sel, SEL_SHR);
            check("rx_sin", sr_sin_right, d[i]);
            check("rx_txrdy", tx_ready, 0);
            check("rx_dv_lo", rx_data_valid, 0);
            @(negedge clk);
        end
        rx_bit_valid = 1'b0;
        rx_start     = 1'b0;
        tx_valid     = 1'b0;
        #1;
        check("rx_done_busy", busy, 1);
        check("rx_done_sel", sr_sel, SEL_HOLD);
        check("rx_done_dv", rx_data_valid, 0);
        @(negedge clk);
        #1;
        check("rx_dv", rx_data_valid, 1);
        check("rx_data", rx_data, d);
        check("rx_post_busy", busy, 0);
    endtask

    initial begin
        bit           tx_won;
        bit           msb;
        logic [W-1:0] d;
        logic [W-1:0] saved;
        int unsigned  kind;

        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_sel", sr_sel, 0);
        check("rst_d", sr_d, 0);
        check("rst_sin", {sr_sin_left, sr_sin_right}, 0);
        check("rst_txrdy", tx_ready, 0);
        check("rst_so", {ser_out, ser_out_valid}, 0);
        check("rst_rxd", {rx_data_valid, rx_data}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        request(1, 0, 4'b1011, 0, tx_won);
        tx_body(4'b1011, 0);
        request(1, 0, 4'b1011, 1, tx_won);
        tx_body(4'b1011, 1);

        request(0, 1, '0, 0, tx_won);
        rx_body(4'b1001, W, 8'h44, 0);

        request(0, 1, '0, 0, tx_won);
        rx_body($urandom_range(0, 15), 2, 8'h00, 0);
        request(0, 1, '0, 0, tx_won);
        rx_body(4'b0110, W, 8'h00, 1);

        // Asynchronous reset one cycle into a TX word.
        request(1, 0, 4'b1100, 1, tx_won);
        tx_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sov", ser_out_valid, 0);
        check("mid_rst_sel", sr_sel, 0);
        check("mid_rst_txrdy", tx_ready, 0);
        saved = reg_q;
        @(negedge clk);
        #1;
        check("mid_rst_sov2", ser_out_valid, 0);
        check("mid_rst_hold", reg_q, saved);
        tx_valid = 1'b0;
        rst      = 1'b1;
        prio_rx  = 1'b0;
        @(negedge clk);

        request(1, 1, 4'b0101, 0, tx_won);
        check("arb_first_tx", tx_won, 1);
        tx_body(4'b0101, 0);
        request(1, 1, 4'b0101, 0, tx_won);
        check("arb_second_rx", tx_won, 0);
        rx_body(4'b1110, W, 8'h00, 1);

        for (int unsigned n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            d    = W'($urandom_range(0, 15));
            msb  = 1'($urandom_range(0, 1));
            request(kind != 1, kind != 0, d, msb, tx_won);
            if (tx_won) begin
                tx_body(d, msb);
            end else begin
                rx_body(W'($urandom_range(0, 15)),
                        ($urandom_range(0, 3) == 0) ? $urandom_range(0, W - 1) : W,
                        8'h00, 1);
            end
            if ($urandom_range(0, 3) == 0) begin
                tx_valid = 1'b0;
                rx_start = 1'b0;
                @(negedge clk);
                #1;
                check("idle_sel", sr_sel, SEL_HOLD);
                check("idle_busy", busy, 0);
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usr_seq_ctrl.md
Name: usr_seq_ctrl

Overview:
Sequencer that owns the sel/d/serial-in controls of one WIDTH-bit universal shift register and time-shares it between a TX requester and an RX requester. TX accepts a parallel word, loads it and shifts it out one bit per cycle. RX clears the register, shifts in WIDTH externally strobed bits and presents the captured word. The block sits between the shift register instance and the serial link logic, with round-robin arbitration between TX and RX.

Parameters:
WIDTH, 4, shift register width; must equal the attached register width (min 2).
CNT_W, 3, bit counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
tx_valid  in  1  TX word offered.
tx_data  in  WIDTH  TX word.
tx_msb_first  in  1  sampled with tx_data: 1 = MSB first (shift left), 0 = LSB first (shift right).
tx_ready  out  1  TX word accepted this cycle (tx_valid & tx_ready = transfer).
ser_out  out  1  current TX serial bit.
ser_out_valid  out  1  ser_out is meaningful this cycle.
rx_start  in  1  request to receive one word.
rx_bit_valid  in  1  rx_bit strobe.
rx_bit  in  1  received serial bit, LSB first.
rx_abort  in  1  abandon the RX in progress.
rx_data  out  WIDTH  captured word.
rx_data_valid  out  1  one-cycle pulse, rx_data valid.
busy  out  1  state != IDLE.
sr_sel  out  2  to register: 00 hold, 01 shift right, 10 shift left, 11 load.
sr_d  out  WIDTH  to register parallel input.
sr_sin_left  out  1  to register serial_in_left (enters q[0] on a left shift).
sr_sin_right  out  1  to register serial_in_right (enters q[WIDTH-1] on a right shift).
sr_q  in  WIDTH  from register output.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, dir=0, prio=TX. Outputs: sr_sel=00, sr_d=0, sr_sin_*=0, tx_ready=0, ser_out=0, ser_out_valid=0, rx_data=0, rx_data_valid=0, busy=0.
- Reset mid-operation aborts immediately. No partial rx_data_valid. The register contents are left untouched (hold).
- State register and counter are registered. All sr_* outputs, tx_ready and ser_out are combinational from state and inputs. rx_data and rx_data_valid are registered.
- Default on every cycle: sr_sel=00, sr_d=0, sr_sin_*=0.
- IDLE, arbitration:
  - If only one of tx_valid and rx_start is asserted, that requester wins.
  - If both are asserted, prio decides; prio then flips to the other requester. A single winner also sets prio to the other requester.
- IDLE, TX win: tx_ready=1, sr_sel=11, sr_d=tx_data, dir<=tx_msb_first, cnt<=0, go to TX_SHIFT.
- IDLE, RX win: sr_sel=11, sr_d=0 (clear), cnt<=0, go to RX_SHIFT.
- TX_SHIFT:
  - ser_out_valid=1. ser_out = dir ? sr_q[WIDTH-1] : sr_q[0].
  - sr_sel = dir ? 10 : 01, fill bits 0. cnt++.
  - When cnt==WIDTH-1, go to IDLE.
  - A word therefore occupies 1+WIDTH cycles. New tx_ready is possible no earlier than the cycle after the last bit.
- RX_SHIFT:
  - rx_abort has priority: go to IDLE, no pulse.
  - Otherwise, if rx_bit_valid: sr_sel=01, sr_sin_right=rx_bit, cnt++. Else sr_sel=00.
  - When a bit is taken with cnt==WIDTH-1, go to RX_DONE.
  - rx_start is ignored while busy.
- RX_DONE: rx_data<=sr_q, rx_data_valid<=1 (pulse on the following cycle), go to IDLE.
  - The first bit received ends in rx_data[0].
  - An incoming request can be granted in the cycle when rx_data_valid is high.
- tx_valid held during RX is only stalled; tx_data must stay stable until tx_ready.
- Counter never exceeds WIDTH-1. Illegal state codes return to IDLE.

Decomposition:
- Package usr_pkg:
  - state enum IDLE/TX_SHIFT/RX_SHIFT/RX_DONE.
  - SEL_HOLD=2'b00, SEL_SHR=2'b01, SEL_SHL=2'b10, SEL_LOAD=2'b11.
  - Grant encoding GNT_TX/GNT_RX.
- One sub-module: usr_rr_arb (2-requester round-robin, prio flop, async active-low reset). The FSM stays in usr_seq_ctrl.

Test Plan:
- Reset mid TX_SHIFT (rst low 1 cycle after load) -> all outputs 0 asynchronously, busy=0, no further ser_out_valid.
- tx_data=4'b1011, tx_msb_first=0 -> sr_sel=11 for 1 cycle, then 4 cycles of 01 with ser_out=1,1,0,1, then busy=0.
- Same word with tx_msb_first=1 -> sr_sel=10 ×4, ser_out=1,0,1,1.
- rx_start, then bits 1,0,0,1 with gaps (rx_bit_valid 1,0,1,1,0,1) -> sr_sel=01 only on strobes; rx_data=4'b1001 with a 1-cycle rx_data_valid pulse; hold cycles show sr_sel=00.
- tx_valid and rx_start both asserted in IDLE from reset, twice -> first grant TX, second grant RX; back-to-back requests alternate.
- rx_abort after 2 bits -> IDLE next cycle, no rx_data_valid; a following rx_start clears the register (sr_sel=11, sr_d=0).
